// File: rtl/lap_record_lcd_if.sv
`default_nettype none
// =============================================================================
// Module   : lap_record_lcd_if
// Brief    : Byte handshake between lap_record_lcd and a character-LCD controller.
// Revision : 1.0
// =============================================================================
interface lap_record_lcd_if;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_Start;
    logic       iLCD_Done;

    modport master (
        output oLCD_DATA,
        output oLCD_RS,
        output oLCD_Start,
        input  iLCD_Done
    );

    modport slave (
        input  oLCD_DATA,
        input  oLCD_RS,
        input  oLCD_Start,
        output iLCD_Done
    );
endinterface
`default_nettype wire

// File: rtl/lap_record_lcd.sv
`default_nettype none
// =============================================================================
// Module   : lap_record_lcd
// Brief    : Stopwatch lap recorder: ring buffer of laps shown on a 2x16 LCD.
//            Define SCROLL_VIEW_EN to enable iScrollUp/iScrollDn view paging.
// Revision : 1.0
// =============================================================================
module lap_record_lcd #(
    parameter int DEPTH      = 8,
    parameter int DLY_CYCLES = 262142
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iRecord_n,
    input  logic             iClear,
    input  logic             iScrollUp,
    input  logic             iScrollDn,
    input  logic [7:0]       iHour,
    input  logic [7:0]       iMinute,
    input  logic [7:0]       iSecond,
    input  logic [7:0]       iCS,
    output logic [6:0]       oCount,
    lap_record_lcd_if.master lcd
);
    localparam int         PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         DLY_W       = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES + 1) : 1;
    localparam logic [5:0] REFRESH_IDX = 6'd4;
    localparam logic [5:0] LAST_IDX    = 6'd37;

    typedef enum logic [2:0] {
        S_INIT      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_DELAY     = 3'd3,
        S_NEXT      = 3'd4,
        S_IDLE      = 3'd5
    } state_t;

    // Saturate to 99 and split into two ASCII digits.
    function automatic logic [15:0] to_ascii2(input logic [7:0] v);
        logic [7:0] sat;
        logic [7:0] tens;
        logic [7:0] units;
        sat   = (v > 8'd99) ? 8'd99 : v;
        tens  = sat / 8'd10;
        units = sat % 8'd10;
        return {8'h30 + tens, 8'h30 + units};
    endfunction

    logic             rec_prev_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [6:0]       count_q, count_d;
    logic [6:0]       lap_q, lap_d;
    logic [5:0]       view_q, view_d;
    logic [79:0]      mem_q [DEPTH];

    state_t           state_q;
    logic [5:0]       idx_q;
    logic [DLY_W-1:0] dly_q;
    logic             dirty_q;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             start_q;

    logic             w_capture;
    logic             w_dirty_set;
    logic             w_refresh_go;
    logic [79:0]      w_new_rec;

    assign w_capture = rec_prev_q & ~iRecord_n & ~iClear;
    assign w_new_rec = {to_ascii2({1'b0, lap_q}), to_ascii2(iHour),
                        to_ascii2(iMinute), to_ascii2(iSecond), to_ascii2(iCS)};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        lap_d    = lap_q;
        if (iClear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            lap_d    = 7'd1;
        end else if (w_capture) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            if (count_q != 7'(DEPTH)) begin
                count_d = count_q + 7'd1;
            end
            lap_d = (lap_q == 7'd99) ? 7'd1 : lap_q + 7'd1;
        end
    end

`ifdef SCROLL_VIEW_EN
    logic [5:0] w_vmax;
    always_comb begin
        w_vmax = (count_q >= 7'd2) ? 6'(count_q - 7'd2) : 6'd0;
        view_d = view_q;
        if (iClear || w_capture) begin
            view_d = '0;
        end else if (iScrollUp && !iScrollDn && (view_q < w_vmax)) begin
            view_d = view_q + 6'd1;
        end else if (iScrollDn && !iScrollUp && (view_q != 6'd0)) begin
            view_d = view_q - 6'd1;
        end
    end
`else
    logic w_unused_scroll;
    assign w_unused_scroll = iScrollUp ^ iScrollDn;
    assign view_d          = '0;
`endif

    assign w_dirty_set = iClear | w_capture | (view_d != view_q);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rec_prev_q <= 1'b1;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            lap_q      <= 7'd1;
            view_q     <= '0;
        end else begin
            rec_prev_q <= iRecord_n;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            lap_q      <= lap_d;
            view_q     <= view_d;
        end
    end

    // Contents need no reset: slots at or beyond oCount are never displayed.
    always_ff @(posedge iCLK) begin
        if (w_capture) begin
            mem_q[wr_ptr_q] <= w_new_rec;
        end
    end

    logic             w_line2;
    logic [3:0]       w_col;
    logic [6:0]       w_k;
    logic [7:0]       w_sum;
    logic [PTR_W-1:0] w_slot;
    logic             w_valid;
    logic [79:0]      w_rec;
    logic [7:0]       w_char;
    logic [7:0]       w_byte;
    logic             w_rs;

    // Line 2 shows record newest-V, line 1 the one before it.
    always_comb begin
        w_line2 = (idx_q >= 6'd22);
        w_col   = w_line2 ? 4'(idx_q - 6'd22) : 4'(idx_q - 6'd5);
        w_k     = w_line2 ? {1'b0, view_q} : ({1'b0, view_q} + 7'd1);
        w_sum   = 8'(wr_ptr_q) + 8'(DEPTH - 1) - {1'b0, w_k};
        w_slot  = (w_sum >= 8'(DEPTH)) ? PTR_W'(w_sum - 8'(DEPTH)) : PTR_W'(w_sum);
        w_valid = (w_k < count_q);
        w_rec   = mem_q[w_slot];
        w_char  = 8'h20;
        case (w_col)
            4'd0:    w_char = w_valid ? w_rec[63:56] : 8'h2D;
            4'd1:    w_char = w_valid ? w_rec[55:48] : 8'h2D;
            4'd2:    w_char = 8'h3A;
            4'd3:    w_char = w_valid ? w_rec[47:40] : 8'h2D;
            4'd4:    w_char = w_valid ? w_rec[39:32] : 8'h2D;
            4'd5:    w_char = 8'h3A;
            4'd6:    w_char = w_valid ? w_rec[31:24] : 8'h2D;
            4'd7:    w_char = w_valid ? w_rec[23:16] : 8'h2D;
            4'd8:    w_char = 8'h27;
            4'd9:    w_char = w_valid ? w_rec[15:8] : 8'h2D;
            4'd10:   w_char = w_valid ? w_rec[7:0] : 8'h2D;
            4'd12:   w_char = w_valid ? 8'h23 : 8'h20;
            4'd13:   w_char = w_valid ? w_rec[79:72] : 8'h20;
            4'd14:   w_char = w_valid ? w_rec[71:64] : 8'h20;
            default: w_char = 8'h20;
        endcase

        w_rs   = 1'b0;
        w_byte = 8'h00;
        case (idx_q)
            6'd0:    w_byte = 8'h38;
            6'd1:    w_byte = 8'h0C;
            6'd2:    w_byte = 8'h01;
            6'd3:    w_byte = 8'h06;
            6'd4:    w_byte = 8'h80;
            6'd21:   w_byte = 8'hC0;
            default: begin
                w_rs   = 1'b1;
                w_byte = w_char;
            end
        endcase
    end

    // Dirty is consumed when a refresh begins; a set in the same cycle wins.
    assign w_refresh_go = ((state_q == S_NEXT) && (idx_q == 6'd3)) ||
                          ((state_q == S_IDLE) && dirty_q);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            dly_q   <= '0;
            dirty_q <= 1'b1;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            start_q <= 1'b0;
        end else begin
            dirty_q <= w_dirty_set | (dirty_q & ~w_refresh_go);
            case (state_q)
                S_INIT: begin
                    idx_q   <= '0;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    data_q  <= w_byte;
                    rs_q    <= w_rs;
                    start_q <= 1'b1;
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (lcd.iLCD_Done) begin
                        start_q <= 1'b0;
                        dly_q   <= '0;
                        state_q <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (dly_q == DLY_W'(DLY_CYCLES - 1)) begin
                        state_q <= S_NEXT;
                    end else begin
                        dly_q <= dly_q + DLY_W'(1);
                    end
                end
                S_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                    end else begin
                        idx_q   <= idx_q + 6'd1;
                        state_q <= S_LOAD;
                    end
                end
                S_IDLE: begin
                    if (dirty_q) begin
                        idx_q   <= REFRESH_IDX;
                        state_q <= S_LOAD;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    assign lcd.oLCD_DATA  = data_q;
    assign lcd.oLCD_RS    = rs_q;
    assign lcd.oLCD_Start = start_q;
    assign oCount         = count_q;
endmodule
`default_nettype wire

// File: tb/tb_lap_record_lcd.sv
`default_nettype none
// =============================================================================
// Module   : tb_lap_record_lcd
// Brief    : Directed self-checking bench for lap_record_lcd with an LCD
//            controller stand-in and a queue-based display model.
// Revision : 1.0
// =============================================================================
module tb_lap_record_lcd;
    localparam int DEPTH = 4;
    localparam int DLY   = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rec_n = 1'b1;
    logic       clr   = 1'b0;
    logic       up    = 1'b0;
    logic       dn    = 1'b0;
    logic [7:0] hh    = 8'd0;
    logic [7:0] mm    = 8'd0;
    logic [7:0] ss    = 8'd0;
    logic [7:0] cs    = 8'd0;
    logic [6:0] count;

    int tests = 0;
    int fails = 0;

    lap_record_lcd_if lcd();

    lap_record_lcd #(.DEPTH(DEPTH), .DLY_CYCLES(DLY)) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iRecord_n (rec_n),
        .iClear    (clr),
        .iScrollUp (up),
        .iScrollDn (dn),
        .iHour     (hh),
        .iMinute   (mm),
        .iSecond   (ss),
        .iCS       (cs),
        .oCount    (count),
        .lcd       (lcd)
    );

    always #5 clk = ~clk;

    // LCD controller stand-in: Done pulses 3 cycles after Start is seen.
    initial begin
        lcd.iLCD_Done = 1'b0;
        forever begin
            @(posedge clk);
            if (lcd.oLCD_Start === 1'b1) begin
                repeat (2) @(posedge clk);
                #1 lcd.iLCD_Done = 1'b1;
                @(posedge clk);
                #1 lcd.iLCD_Done = 1'b0;
            end
        end
    end

    typedef struct {
        int lap;
        int h;
        int m;
        int s;
        int c;
    } rec_t;

    rec_t         m_q[$];
    int           m_lap     = 1;
    int           m_v       = 0;
    bit           m_dirty   = 1'b1;
    int           m_idx     = 0;
    int           n_refresh = 0;
    bit           from_idle = 1'b0;
    logic [8:0]   blog[$];
    logic [127:0] l1 = '0;
    logic [127:0] l2 = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x > 99) ? 99 : x;
    endfunction

    function automatic string m_line(input int k);
        rec_t r;
        if (k >= m_q.size()) return "--:--:--'--     ";
        r = m_q[m_q.size() - 1 - k];
        return $sformatf("%02d:%02d:%02d'%02d #%02d ", sat(r.h), sat(r.m), sat(r.s), sat(r.c), r.lap);
    endfunction

    function automatic logic [8:0] m_byte(input int i);
        string s;
        case (i)
            0:  return 9'h038;
            1:  return 9'h00C;
            2:  return 9'h001;
            3:  return 9'h006;
            4:  return 9'h080;
            21: return 9'h0C0;
            default: ;
        endcase
        if (i < 21) begin
            s = m_line(m_v + 1);
            return {1'b1, s[i - 5]};
        end
        s = m_line(m_v);
        return {1'b1, s[i - 22]};
    endfunction

    logic       sp = 1'b0;
    logic       dp = 1'b0;
    int         low_cnt = 0;
    logic [8:0] c_act;
    logic [8:0] c_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            sp      = 1'b0;
            dp      = 1'b0;
            low_cnt = 0;
        end else begin
            chk("oCount", 128'(count), 128'(m_q.size()));
            if (sp) chk("start_hold", 128'(lcd.oLCD_Start), 128'(!dp));
            if (lcd.oLCD_Start && !sp) begin
                c_act = {lcd.oLCD_RS, lcd.oLCD_DATA};
                if (m_idx == 38) begin
                    chk("unexpected_refresh", 128'(m_dirty), 128'(1));
                    m_idx     = 4;
                    from_idle = 1'b1;
                end
                if (m_idx != 0 && !from_idle) chk("byte_gap", 128'(low_cnt), 128'(DLY + 2));
                if (m_idx == 4) m_dirty = 1'b0;
                c_exp = m_byte(m_idx);
                chk($sformatf("byte%0d", m_idx), 128'(c_act), 128'(c_exp));
                blog.push_back(c_act);
                if (m_idx >= 5 && m_idx <= 20) l1[127 - 8 * (m_idx - 5) -: 8] = c_act[7:0];
                if (m_idx >= 22 && m_idx <= 37) l2[127 - 8 * (m_idx - 22) -: 8] = c_act[7:0];
                if (m_idx == 37) begin
                    m_idx = 38;
                    n_refresh++;
                end else begin
                    m_idx++;
                end
                from_idle = 1'b0;
            end
            low_cnt = lcd.oLCD_Start ? 0 : low_cnt + 1;
            sp      = lcd.oLCD_Start;
            dp      = lcd.iLCD_Done;
        end
    end

    task automatic press(input int h, input int m, input int s, input int c);
        rec_t r;
        @(negedge clk);
        hh    = 8'(h);
        mm    = 8'(m);
        ss    = 8'(s);
        cs    = 8'(c);
        rec_n = 1'b0;
        @(posedge clk);
        #1;
        r.lap = m_lap; r.h = h; r.m = m; r.s = s; r.c = c;
        m_q.push_back(r);
        if (m_q.size() > DEPTH) m_q.delete(0);
        m_lap   = (m_lap == 99) ? 1 : m_lap + 1;
        m_v     = 0;
        m_dirty = 1'b1;
        @(negedge clk);
        rec_n = 1'b1;
    endtask

    task automatic clear_with_press();
        @(negedge clk);
        clr   = 1'b1;
        rec_n = 1'b0;
        @(posedge clk);
        #1;
        m_q.delete();
        m_lap   = 1;
        m_v     = 0;
        m_dirty = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        rec_n = 1'b1;
    endtask

    task automatic scroll(input bit u, input bit d);
        int vmax;
        @(negedge clk);
        up = u;
        dn = d;
        @(posedge clk);
        #1;
        vmax = (m_q.size() >= 2) ? m_q.size() - 2 : 0;
`ifdef SCROLL_VIEW_EN
        if (u && !d && m_v < vmax) begin
            m_v++;
            m_dirty = 1'b1;
        end else if (d && !u && m_v > 0) begin
            m_v--;
            m_dirty = 1'b1;
        end
`endif
        @(negedge clk);
        up = 1'b0;
        dn = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(m_idx == 38 && !m_dirty) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk("idle_timeout", 128'(0), 128'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (m_idx != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("byte_index_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        logic [127:0] dash;
        int           nr;
        int           nb;
        dash = "--:--:--'--     ";

        repeat (3) @(negedge clk);
        chk("rst_data",  128'(lcd.oLCD_DATA),  128'(0));
        chk("rst_rs",    128'(lcd.oLCD_RS),    128'(0));
        chk("rst_start", 128'(lcd.oLCD_Start), 128'(0));
        chk("rst_count", 128'(count),          128'(0));
        rst_n = 1'b1;

        wait_idle();
        chk("init_total_bytes", 128'(blog.size()), 128'(38));
        chk("init_b0",  128'(blog[0]),  128'(9'h038));
        chk("init_b1",  128'(blog[1]),  128'(9'h00C));
        chk("init_b2",  128'(blog[2]),  128'(9'h001));
        chk("init_b3",  128'(blog[3]),  128'(9'h006));
        chk("init_b4",  128'(blog[4]),  128'(9'h080));
        chk("init_b21", 128'(blog[21]), 128'(9'h0C0));
        chk("init_line1", l1, dash);
        chk("init_line2", l2, dash);

        press(12, 34, 56, 78);
        wait_idle();
        chk("lap1_line2", l2, "12:34:56'78 #01 ");
        chk("lap1_line1", l1, dash);
        chk("lap1_count", 128'(count), 128'(1));

        press(150, 5, 7, 3);
        wait_idle();
        chk("sat_line2", l2, "99:05:07'03 #02 ");
        chk("sat_line1", l1, "12:34:56'78 #01 ");

        press(1, 2, 3, 4);
        wait_idle();

        nr = n_refresh;
        nb = blog.size();
        press(10, 20, 30, 40);
        wait_idx(15);
        press(11, 22, 33, 44);
        wait_idle();
        chk("midrefresh_refreshes", 128'(n_refresh - nr), 128'(2));
        chk("midrefresh_bytes", 128'(blog.size() - nb), 128'(68));
        chk("midrefresh_line2", l2, "11:22:33'44 #05 ");
        chk("midrefresh_line1", l1, "10:20:30'40 #04 ");

        press(0, 0, 0, 99);
        wait_idle();
        chk("full_count", 128'(count), 128'(4));
        chk("full_line2", l2, "00:00:00'99 #06 ");
        chk("full_line1", l1, "11:22:33'44 #05 ");

`ifdef SCROLL_VIEW_EN
        repeat (3) begin
            scroll(1'b1, 1'b0);
            wait_idle();
        end
        chk("scroll_line2", l2, "10:20:30'40 #04 ");
        chk("scroll_line1", l1, "01:02:03'04 #03 ");
        nr = n_refresh;
        scroll(1'b1, 1'b1);
        repeat (50) @(negedge clk);
        chk("scroll_both_ignored", 128'(n_refresh), 128'(nr));
        scroll(1'b0, 1'b1);
        wait_idle();
        chk("scrolldn_line2", l2, "11:22:33'44 #05 ");
        chk("scrolldn_line1", l1, "10:20:30'40 #04 ");
`else
        nr = n_refresh;
        scroll(1'b1, 1'b0);
        repeat (50) @(negedge clk);
        chk("scroll_ignored", 128'(n_refresh), 128'(nr));
`endif

        clear_with_press();
        wait_idle();
        chk("clear_count", 128'(count), 128'(0));
        chk("clear_line1", l1, dash);
        chk("clear_line2", l2, dash);

        nr = n_refresh;
        scroll(1'b1, 1'b0);
        repeat (50) @(negedge clk);
        chk("clear_scroll_no_refresh", 128'(n_refresh), 128'(nr));

        press(5, 6, 7, 8);
        wait_idle();
        chk("restart_line2", l2, "05:06:07'08 #01 ");
        chk("restart_count", 128'(count), 128'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
